// File: rtl/register_file_pkg.sv
// Shared widths, depth and FSM state type for the register-file bus master.
package register_file_pkg;

    localparam int DEFAULT_WIDTH1 = 32;
    localparam int DEFAULT_WIDTH2 = 5;
    localparam int DEPTH          = 1 << DEFAULT_WIDTH2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

endpackage

// File: rtl/register_file_master_rsp_slot.sv
// Single-entry read-response holding register with valid/ready handshake.
module register_file_master_rsp_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // NOTE: the data register is reset too, because the response port has a defined reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/register_file_master.sv
// Burst initiator for the sel/wr/addr/wdata/rdata register-file bus.
// Optional beat counters (wr_count/rd_count) when REGISTER_FILE_MASTER_STATS_EN is defined.
module register_file_master
    import register_file_pkg::*;
#(
    parameter int WIDTH1 = DEFAULT_WIDTH1,
    parameter int WIDTH2 = DEFAULT_WIDTH2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [WIDTH2-1:0] cmd_addr,
    input  logic [WIDTH2-1:0] cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [WIDTH1-1:0] wd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH1-1:0] rsp_data,
    output logic              done,
    output logic              sel,
    output logic              wr,
    output logic [WIDTH2-1:0] addr,
    output logic [WIDTH1-1:0] wdata,
    input  logic [WIDTH1-1:0] rdata
`ifdef REGISTER_FILE_MASTER_STATS_EN
    ,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
`endif
);

    state_t            state;
    logic [WIDTH2-1:0] addr_q;
    logic [WIDTH2-1:0] remaining;
    logic              issue;

    assign issue = !rsp_valid || rsp_ready;
    assign addr  = addr_q;
    assign wdata = wd_data;

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        cmd_ready = 1'b0;
        wd_ready  = 1'b0;
        sel       = 1'b0;
        wr        = 1'b0;
        case (state)
            IDLE:  cmd_ready = !rsp_valid;
            WRITE: begin
                wd_ready = 1'b1;
                wr       = 1'b1;
                sel      = wd_valid;
            end
            READ:  sel = issue;
            default: ;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q    <= cmd_addr;
                        remaining <= cmd_len;
                        state     <= cmd_wr ? WRITE : READ;
                    end
                end
                WRITE, READ: begin
                    // sel marks a real bus beat in either direction
                    if (sel) begin
                        addr_q    <= addr_q + WIDTH2'(1);
                        remaining <= remaining - WIDTH2'(1);
                        if (remaining == '0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    register_file_master_rsp_slot #(
        .WIDTH(WIDTH1)
    ) u_rsp_slot (
        .clk      (clk),
        .reset    (reset),
        .load     (sel && !wr),
        .load_data(rdata),
        .ready    (rsp_ready),
        .valid    (rsp_valid),
        .data     (rsp_data)
    );

`ifdef REGISTER_FILE_MASTER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (sel && wr && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
            if (sel && !wr && rd_count != 16'hFFFF)
                rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_register_file_master.sv
// Self-checking bench for register_file_master: behavioural register file plus a
// spec-level memory model; optional counters checked when REGISTER_FILE_MASTER_STATS_EN is set.
module tb_register_file_master;
    import register_file_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0] cmd_addr, cmd_len;
    logic          wd_valid, wd_ready;
    logic [DW-1:0] wd_data;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          done, sel, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
`ifdef REGISTER_FILE_MASTER_STATS_EN
    logic [15:0]   wr_count, rd_count;
`endif

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] rf      [DEPTH];
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] wbuf    [DEPTH];
    int            exp_wr = 0;
    int            exp_rd = 0;

    always #5 clk = ~clk;

    register_file_master dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .done(done), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata)
`ifdef REGISTER_FILE_MASTER_STATS_EN
        , .wr_count(wr_count), .rd_count(rd_count)
`endif
    );

    // Behavioural register file: synchronous write, combinational read, cleared by reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) rf[k] <= '0;
        end else if (sel && wr) begin
            rf[addr] <= wdata;
        end
    end
    assign rdata = (sel && !wr) ? rf[addr] : '0;

    task automatic clear_model();
        for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;
        exp_wr = 0;
        exp_rd = 0;
    endtask

    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] l);
        int t;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_len = l;
        #1;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 50) begin
            @(negedge clk); #1; t++;
        end
        n_cmp++;
        if (t >= 50) begin n_bad++; $display("FAIL cmd_accept: cmd_ready=%b want 1", cmd_ready); end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l, input bit gaps);
        int i, cyc;
        bit gap;
        logic [AW-1:0] ea;
        send_cmd(1'b1, a, l);
        i = 0; cyc = 0;
        while (i <= int'(l) && cyc < 300) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            gap = gaps && ($urandom_range(0, 2) == 0);
            wd_valid = !gap;
            wd_data  = wbuf[i];
            #1;
            ea = a + AW'(i);
            n_cmp++;
            if (done !== 1'b0 || wd_ready !== 1'b1) begin
                n_bad++; $display("FAIL wr_flags: done=%b wd_ready=%b want 0/1", done, wd_ready);
            end
            n_cmp++;
            if (gap) begin
                if (sel !== 1'b0) begin n_bad++; $display("FAIL wr_gap_sel: sel=%b want 0", sel); end
            end else begin
                if (sel !== 1'b1 || wr !== 1'b1 || addr !== ea || wdata !== wbuf[i]) begin
                    n_bad++;
                    $display("FAIL wr_beat: sel=%b wr=%b addr=%0d data=%h want 1/1/%0d/%h",
                             sel, wr, addr, wdata, ea, wbuf[i]);
                end
                exp_mem[ea] = wbuf[i];
                i++;
            end
            cyc++;
        end
        n_cmp++;
        if (i != int'(l) + 1) begin n_bad++; $display("FAIL wr_timeout: beats=%0d want %0d", i, int'(l) + 1); end
        @(negedge clk);
        wd_valid = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b1 || cmd_ready !== 1'b1 || wd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_done: done=%b cmd_ready=%b wd_ready=%b want 1/1/0", done, cmd_ready, wd_ready);
        end
        exp_wr += int'(l) + 1;
        @(negedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL wr_done_once: done=%b want 0", done); end
    endtask

    // mode 0: rsp_ready held high; 1: toggles every cycle; 2: random
    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l, input int mode);
        logic [DW-1:0] q[$];
        int issued, got, dones, cyc;
        bit first, prev_sel;
        logic [AW-1:0] ea;
        logic [DW-1:0] want;
        for (int i = 0; i <= int'(l); i++) q.push_back(exp_mem[a + AW'(i)]);
        send_cmd(1'b0, a, l);
        issued = 0; got = 0; dones = 0; cyc = 0; first = 1'b1; prev_sel = 1'b0;
        rsp_ready = 1'b0;
        while ((got <= int'(l) || dones == 0) && cyc < 300) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            case (mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ~rsp_ready;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (first) begin
                n_cmp++;
                if (sel !== 1'b1 || rsp_valid !== 1'b0) begin
                    n_bad++; $display("FAIL rd_latency: sel=%b rsp_valid=%b want 1/0", sel, rsp_valid);
                end
                first = 1'b0;
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b0) begin
                n_cmp++;
                if (sel !== 1'b0) begin n_bad++; $display("FAIL rd_stall_sel: sel=%b want 0", sel); end
            end
            if (sel === 1'b1) begin
                ea = a + AW'(issued);
                n_cmp++;
                if (wr !== 1'b0 || addr !== ea || issued > int'(l)) begin
                    n_bad++;
                    $display("FAIL rd_issue: wr=%b addr=%0d n=%0d want 0/%0d/<=%0d", wr, addr, issued, ea, int'(l));
                end
                issued++;
            end
            if (done === 1'b1) begin
                dones++;
                n_cmp++;
                if (issued != int'(l) + 1 || rsp_valid !== 1'b1 || !prev_sel || cmd_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rd_done_timing: issued=%0d rsp_valid=%b prev_sel=%b cmd_ready=%b want %0d/1/1/0",
                             issued, rsp_valid, prev_sel, cmd_ready, int'(l) + 1);
                end
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                want = (q.size() > 0) ? q.pop_front() : 'x;
                n_cmp++;
                if (rsp_data !== want) begin
                    n_bad++; $display("FAIL rd_data: beat=%0d got=%h want=%h", got, rsp_data, want);
                end
                got++;
            end
            prev_sel = sel;
            cyc++;
        end
        n_cmp++;
        if (cyc >= 300 || dones != 1 || got != int'(l) + 1) begin
            n_bad++;
            $display("FAIL rd_burst_end: beats=%0d dones=%0d want %0d/1", got, dones, int'(l) + 1);
        end
        exp_rd += int'(l) + 1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || done !== 1'b0 || sel !== 1'b0) begin
            n_bad++; $display("FAIL rd_after: rsp_valid=%b done=%b sel=%b want 0/0/0", rsp_valid, done, sel);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wd_valid = 1'b0; wd_data = '0; rsp_ready = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1 || wd_ready !== 1'b0 || sel !== 1'b0 || wr !== 1'b0 ||
            rsp_valid !== 1'b0 || rsp_data !== '0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: cmd_ready=%b wd_ready=%b sel=%b wr=%b rsp_valid=%b rsp_data=%h done=%b",
                     cmd_ready, wd_ready, sel, wr, rsp_valid, rsp_data, done);
        end
        reset = 1'b0;
        // write data offered while idle must be ignored
        @(negedge clk);
        wd_valid = 1'b1; wd_data = 32'h1234_5678; rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (wd_ready !== 1'b0 || sel !== 1'b0 || rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL idle_ignore: wd_ready=%b sel=%b rsp_valid=%b want 0/0/0", wd_ready, sel, rsp_valid);
        end
        @(negedge clk);
        wd_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic test_single();
        wbuf[0] = 32'hDEAD_BEEF;
        do_write(5'd3, 5'd0, 1'b0);
        do_read(5'd3, 5'd0, 2);
    endtask

    task automatic test_wrap_write();
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h10 + i;
        do_write(5'd30, 5'd3, 1'b1);
        do_read(5'd30, 5'd3, 0);
    endtask

    task automatic test_backpressure();
        do_read(5'd0, 5'd7, 1);
    endtask

    task automatic test_full_sweep();
        for (int k = 0; k < DEPTH; k++) wbuf[k] = k * 3;
        do_write(5'd0, 5'd31, 1'b0);
        do_read(5'd0, 5'd31, 0);
    endtask

    task automatic test_reset_mid_read();
        int issued, cyc;
        send_cmd(1'b0, 5'd2, 5'd9);
        issued = 0; cyc = 0;
        while (issued < 4 && cyc < 50) begin
            @(negedge clk);
            cmd_valid = 1'b0; rsp_ready = 1'b1;
            #1;
            if (sel === 1'b1) issued++;
            cyc++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || sel !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: rsp_valid=%b sel=%b cmd_ready=%b done=%b want 0/0/1/0",
                     rsp_valid, sel, cmd_ready, done);
        end
        reset = 1'b0; rsp_ready = 1'b0;
        clear_model();
        repeat (2) begin
            @(negedge clk); #1;
            n_cmp++;
            if (done !== 1'b0) begin n_bad++; $display("FAIL mid_reset_done: done=%b want 0", done); end
        end
        do_read(AW'($urandom), 5'd0, 0);
        do_read(5'd5, 5'd3, 2);
    endtask

    task automatic test_random();
        logic [AW-1:0] a, l;
        for (int n = 0; n < 14; n++) begin
            a = AW'($urandom);
            l = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
                do_write(a, l, 1'b1);
            end else begin
                do_read(a, l, 2);
            end
        end
    endtask

    task automatic test_stats();
`ifdef REGISTER_FILE_MASTER_STATS_EN
        n_cmp++;
        if (wr_count !== 16'(exp_wr) || rd_count !== 16'(exp_rd)) begin
            n_bad++;
            $display("FAIL stats: wr_count=%0d rd_count=%0d want %0d/%0d", wr_count, rd_count, exp_wr, exp_rd);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap_write();
        test_backpressure();
        test_full_sweep();
        test_reset_mid_read();
        test_random();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
